// File: rtl/gpio_debouncer.sv
// gpio_debouncer: per-channel sync chain, shared sample prescaler,
// stability counters, and registered rise/fall event pulses.
module gpio_debouncer #(
  parameter int CHANNELS        = 3,
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int SAMPLE_RATE_HZ  = 1000,
  parameter int STABLE_SAMPLES  = 16,
  parameter int SYNC_STAGES     = 2,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_input,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                changed,
  output logic                sample_tick
);

  localparam int DIVIDER = CLOCK_FREQUENCY / SAMPLE_RATE_HZ;
  localparam int PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int CW =
    (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;

  logic [PW-1:0]       r_presc;
  logic                r_sample_tick;
  logic                w_tick;
  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] w_synced;
  logic [CW-1:0]       r_cnt [CHANNELS];
  logic [CW-1:0]       w_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] r_deb;
  logic [CHANNELS-1:0] w_deb_nxt;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] w_rise_nxt;
  logic [CHANNELS-1:0] w_fall_nxt;
  logic                r_changed;

  assign w_tick   = (r_presc == PW'(DIVIDER - 1));
  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc       <= '0;
      r_sample_tick <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + PW'(1);
      r_sample_tick <= w_tick;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        r_sync[s] <= RESET_VALUE;
    end else begin
      r_sync[0] <= raw_input;
      for (int s = 1; s < SYNC_STAGES; s++)
        r_sync[s] <= r_sync[s-1];
    end
  end

  // Any matching sample clears progress; a flip needs an
  // unbroken run of STABLE_SAMPLES disagreeing ticks.
  always_comb begin
    w_deb_nxt  = r_deb;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_tick) begin
        if (w_synced[i] == r_deb[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CW'(STABLE_SAMPLES - 1)) begin
          w_cnt_nxt[i]  = '0;
          w_deb_nxt[i]  = w_synced[i];
          w_rise_nxt[i] = w_synced[i];
          w_fall_nxt[i] = ~w_synced[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++)
        r_cnt[i] <= '0;
      r_deb     <= RESET_VALUE;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        r_cnt[i] <= w_cnt_nxt[i];
      r_deb     <= w_deb_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |{w_rise_nxt, w_fall_nxt};
    end
  end

  assign debounced   = r_deb;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign changed     = r_changed;
  assign sample_tick = r_sample_tick;

endmodule

// File: tb/tb_gpio_debouncer.sv
// tb_gpio_debouncer: directed tests for gpio_debouncer in the
// DIVIDER=4/STABLE=3 setup and the DIVIDER=1/STABLE=1 setup.
module tb_gpio_debouncer;

  logic       clock = 1'b0;
  logic       reset, reset2;
  logic [2:0] raw, raw2;
  logic [2:0] deb, rise, fall;
  logic       chg, stk;
  logic [2:0] deb2, rise2, fall2;
  logic       chg2, stk2;
  int         n_run  = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  gpio_debouncer #(
    .CHANNELS(3), .CLOCK_FREQUENCY(1000), .SAMPLE_RATE_HZ(250),
    .STABLE_SAMPLES(3), .SYNC_STAGES(2), .RESET_VALUE(3'b000)
  ) dut (
    .clock(clock), .reset(reset), .raw_input(raw),
    .debounced(deb), .rise_pulse(rise), .fall_pulse(fall),
    .changed(chg), .sample_tick(stk)
  );

  gpio_debouncer #(
    .CHANNELS(3), .CLOCK_FREQUENCY(1000), .SAMPLE_RATE_HZ(1000),
    .STABLE_SAMPLES(1), .SYNC_STAGES(2), .RESET_VALUE(3'b000)
  ) dut2 (
    .clock(clock), .reset(reset2), .raw_input(raw2),
    .debounced(deb2), .rise_pulse(rise2), .fall_pulse(fall2),
    .changed(chg2), .sample_tick(stk2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Expected {debounced, rise, fall, changed, sample_tick};
  // ticks land on cycles 4, 8, 12, ... after reset release.
  function automatic logic [10:0] exp_main(
    logic [2:0] d, logic [2:0] r, logic [2:0] f, int cyc);
    logic t;
    t = (cyc > 0) && (cyc % 4 == 0);
    return {d, r, f, |(r | f), t};
  endfunction

  task automatic test_reset();
    logic [10:0] got, exp;
    raw = 3'b000;
    do_reset();
    got = {deb, rise, fall, chg, stk};
    n_run++;
    if (got !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_vals got=%b exp=%b", got, 11'b0);
    end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      got = {deb, rise, fall, chg, stk};
      exp = exp_main(3'b000, 3'b000, 3'b000, cyc);
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_tick cyc=%0d got=%b exp=%b",
                 cyc, got, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [10:0] got, exp;
    raw = 3'b000;
    do_reset();
    for (int j = 0; j < 20; j++) begin
      raw = 3'b001;
      step();
      got = {deb, rise, fall, chg, stk};
      exp = exp_main((j + 1 >= 12) ? 3'b001 : 3'b000,
                     (j + 1 == 12) ? 3'b001 : 3'b000,
                     3'b000, j + 1);
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL press cyc=%0d got=%b exp=%b",
                 j + 1, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [10:0] got, exp;
    logic        b;
    raw = 3'b000;
    do_reset();
    for (int j = 0; j < 60; j++) begin
      if (j < 16)      b = ((j / 4) % 2 == 0);
      else if (j < 28) b = 1'b0;
      else if (j < 36) b = 1'b1;
      else if (j < 40) b = 1'b0;
      else             b = 1'b1;
      raw = {1'b0, b, 1'b0};
      step();
      got = {deb, rise, fall, chg, stk};
      exp = exp_main((j + 1 >= 52) ? 3'b010 : 3'b000,
                     (j + 1 == 52) ? 3'b010 : 3'b000,
                     3'b000, j + 1);
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b",
                 j + 1, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, exp;
    logic [2:0]  d;
    raw = 3'b000;
    do_reset();
    for (int j = 0; j < 40; j++) begin
      raw = (j < 20) ? 3'b101 : 3'b000;
      step();
      d = (j + 1 >= 12 && j + 1 < 32) ? 3'b101 : 3'b000;
      got = {deb, rise, fall, chg, stk};
      exp = exp_main(d,
                     (j + 1 == 12) ? 3'b101 : 3'b000,
                     (j + 1 == 32) ? 3'b101 : 3'b000,
                     j + 1);
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL simul cyc=%0d got=%b exp=%b",
                 j + 1, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, exp;
    raw = 3'b000;
    do_reset();
    for (int j = 0; j < 10; j++) begin
      raw = 3'b100;
      step();
      got = {deb, rise, fall, chg, stk};
      exp = exp_main(3'b000, 3'b000, 3'b000, j + 1);
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midcnt_pre cyc=%0d got=%b exp=%b",
                 j + 1, got, exp);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = {deb, rise, fall, chg, stk};
    n_run++;
    if (got !== 11'b0) begin
      n_fail++;
      $display("FAIL midcnt_rst got=%b exp=%b", got, 11'b0);
    end
    for (int j = 0; j < 20; j++) begin
      step();
      got = {deb, rise, fall, chg, stk};
      exp = exp_main((j + 1 >= 12) ? 3'b100 : 3'b000,
                     (j + 1 == 12) ? 3'b100 : 3'b000,
                     3'b000, j + 1);
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midcnt_post cyc=%0d got=%b exp=%b",
                 j + 1, got, exp);
      end
    end
  endtask

  function automatic logic [2:0] pat(int j);
    logic [2:0] tbl [16];
    tbl = '{3'b000, 3'b001, 3'b001, 3'b011,
            3'b010, 3'b110, 3'b111, 3'b111,
            3'b000, 3'b101, 3'b101, 3'b010,
            3'b010, 3'b000, 3'b111, 3'b000};
    if (j < 0 || j >= 16) return 3'b000;
    return tbl[j];
  endfunction

  // Output follows raw with three cycles of latency.
  task automatic test_degenerate();
    logic [10:0] got, exp;
    logic [2:0]  d, p, r, f;
    raw2   = 3'b000;
    reset2 = 1'b1;
    repeat (3) step();
    reset2 = 1'b0;
    got = {deb2, rise2, fall2, chg2, stk2};
    n_run++;
    if (got !== 11'b0) begin
      n_fail++;
      $display("FAIL degen_rst got=%b exp=%b", got, 11'b0);
    end
    for (int j = 0; j < 22; j++) begin
      raw2 = pat(j);
      step();
      d = pat(j + 1 - 3);
      p = pat(j + 1 - 4);
      r = d & ~p;
      f = ~d & p;
      exp = {d, r, f, |(r | f), 1'b1};
      got = {deb2, rise2, fall2, chg2, stk2};
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL degen cyc=%0d got=%b exp=%b",
                 j + 1, got, exp);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    reset2 = 1'b1;
    raw    = 3'b000;
    raw2   = 3'b000;
    step();
    test_reset();
    test_clean_press();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_degenerate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
